// File: rtl/avalon_mem_tester.sv
// Avalon-MM host memory tester: fills a word region with SEED+i, reads it back,
// and reports the mismatch count and the address of the first mismatch.
module avalon_mem_tester #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NWORDS_W  = 4,
  parameter logic [31:0] SEED      = 32'hA5A5_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [31:0] first_err_addr,
  output logic [31:0] address,
  output logic [3:0]  byteenable,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  input  logic        readdatavalid
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_RD_REQ  = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [NWORDS_W-1:0] LAST_IDX = '1;

  logic [2:0]          state;
  logic [NWORDS_W-1:0] idx;
  logic [31:0]         expected;
  logic                mismatch;
  logic                last_word;

  assign expected  = SEED + 32'(idx);
  assign mismatch  = (readdata != expected);
  assign last_word = (idx == LAST_IDX);

  // The address register walks alongside idx so it always names the word being
  // written, requested or compared; first_err_addr is latched straight from it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      idx            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= 16'h0000;
      first_err_addr <= 32'h0;
      address        <= 32'h0;
      byteenable     <= 4'h0;
      read           <= 1'b0;
      write          <= 1'b0;
      writedata      <= 32'h0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_WR;
            idx            <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 16'h0000;
            first_err_addr <= 32'h0;
            address        <= BASE_ADDR;
            byteenable     <= 4'hF;
            write          <= 1'b1;
            read           <= 1'b0;
            writedata      <= SEED;
          end
        end

        S_WR: begin
          if (!waitrequest) begin
            if (last_word) begin
              state   <= S_RD_REQ;
              idx     <= '0;
              write   <= 1'b0;
              read    <= 1'b1;
              address <= BASE_ADDR;
            end else begin
              idx       <= idx + 1'b1;
              address   <= address + 32'd4;
              writedata <= writedata + 32'd1;
            end
          end
        end

        S_RD_REQ: begin
          if (!waitrequest) begin
            state <= S_RD_WAIT;
            read  <= 1'b0;
          end
        end

        S_RD_WAIT: begin
          if (readdatavalid) begin
            if (mismatch) begin
              if (err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
              end
              if (err_count == 16'h0000) begin
                first_err_addr <= address;
              end
            end
            // Pass folds in this final compare so done and pass rise together.
            if (last_word) begin
              state      <= S_DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              pass       <= (err_count == 16'h0000) && !mismatch;
              byteenable <= 4'h0;
            end else begin
              state   <= S_RD_REQ;
              idx     <= idx + 1'b1;
              address <= address + 32'd4;
              read    <= 1'b1;
            end
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          read  <= 1'b0;
          write <= 1'b0;
        end
      endcase
    end
  end

endmodule
